// File: rtl/reset_seq_pkg.sv
// Shared types for the reset sequencer: FSM state encoding and reset cause codes.
`timescale 1ns/1ps
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD      = 2'd0,
    WAIT_LOCK = 2'd1,
    RELEASE   = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_POR  = 2'd0;
  localparam logic [1:0] CAUSE_BTN  = 2'd1;
  localparam logic [1:0] CAUSE_SW   = 2'd2;
  localparam logic [1:0] CAUSE_LOCK = 2'd3;

endpackage

// File: rtl/reset_sequencer_sync_debounce.sv
// Multi-flop synchroniser for one async input, followed by a saturating
// low-level debouncer that flags an input held low for DEBOUNCE_CYCLES cycles.
`timescale 1ns/1ps
module sync_debounce #(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 1,
  parameter logic RESET_VAL       = 1'b1
) (
  input  logic clkout,
  input  logic ext_reset,
  input  logic din,
  output logic level,
  output logic evt
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      sync_q <= {SYNC_STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
    end
  end

  assign level = sync_q[SYNC_STAGES-1];

  // Any high sample restarts the count; the count parks at DB_MAX while held low.
  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      cnt_q <= '0;
    end else if (level) begin
      cnt_q <= '0;
    end else if (cnt_q != DB_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign evt = (cnt_q == DB_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// Board reset controller: synchronises ext_reset, waits for PLL lock, then
// releases NUM_OUTS reset domains in order, and records the last reset cause.
//
//   state     | meaning
//   HOLD      | all domains in reset, step counter times the hold period
//   WAIT_LOCK | waiting for synchronised pll_lock
//   RELEASE   | releasing one domain every STAGE_DELAY cycles, bit 0 first
//   RUN       | all domains released, por_done high
`timescale 1ns/1ps
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_OUTS        = 4,
  parameter int SYNC_STAGES     = 2,
  parameter int STAGE_DELAY     = 16,
  parameter int DEBOUNCE_CYCLES = 65536
) (
  input  logic                clkout,
  input  logic                ext_reset,
  input  logic                pll_lock,
  input  logic                btn_rst_n,
  input  logic                sw_req,
  output logic [NUM_OUTS-1:0] rst_n_out,
  output logic                por_done,
  output logic [1:0]          reset_cause,
  output logic [1:0]          state_o
);

  localparam int SW = (STAGE_DELAY > 1) ? $clog2(STAGE_DELAY) : 1;
  localparam int IW = $clog2(NUM_OUTS + 1);
  localparam logic [SW-1:0] STEP_LAST = SW'(STAGE_DELAY - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_OUTS - 1);

  logic [SYNC_STAGES-1:0] rst_chain_q;
  logic                   rst_sync;
  logic                   lock_sync;
  logic                   lock_low_unused;
  logic                   btn_level_unused;
  logic                   btn_evt;

  state_t                 state_q, state_d;
  logic [SW-1:0]          step_q, step_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [NUM_OUTS-1:0]    rst_q, rst_d;
  logic                   por_q, por_d;
  logic [1:0]             cause_q, cause_d;
  logic                   lock_q;

  logic                   active;
  logic                   lock_loss;
  logic                   btn_trig;
  logic                   sw_trig;

  // Assertion is immediate; deassertion reaches the FSM only after the chain fills.
  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      rst_chain_q <= '0;
    end else begin
      rst_chain_q <= {rst_chain_q[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign rst_sync = rst_chain_q[SYNC_STAGES-1];

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (1),
    .RESET_VAL       (1'b0)
  ) u_lock_sync (
    .clkout    (clkout),
    .ext_reset (ext_reset),
    .din       (pll_lock),
    .level     (lock_sync),
    .evt       (lock_low_unused)
  );

  sync_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .RESET_VAL       (1'b1)
  ) u_btn_sync (
    .clkout    (clkout),
    .ext_reset (ext_reset),
    .din       (btn_rst_n),
    .level     (btn_level_unused),
    .evt       (btn_evt)
  );

  assign active    = (state_q == RELEASE) || (state_q == RUN);
  assign lock_loss = active && lock_q && !lock_sync;
  assign btn_trig  = btn_evt && (state_q != HOLD);
  assign sw_trig   = active && sw_req;

  always_ff @(posedge clkout or negedge ext_reset) begin
    if (!ext_reset) begin
      state_q <= HOLD;
      step_q  <= '0;
      idx_q   <= '0;
      rst_q   <= '0;
      por_q   <= 1'b0;
      cause_q <= CAUSE_POR;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      por_q   <= por_d;
      cause_q <= cause_d;
      lock_q  <= lock_sync;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    por_d   = por_q;
    cause_d = cause_q;

    if (lock_loss || btn_trig || sw_trig) begin
      state_d = HOLD;
      step_d  = '0;
      idx_d   = '0;
      rst_d   = '0;
      por_d   = 1'b0;
      if (lock_loss)     cause_d = CAUSE_LOCK;
      else if (btn_trig) cause_d = CAUSE_BTN;
      else               cause_d = CAUSE_SW;
    end else begin
      unique case (state_q)
        HOLD: begin
          rst_d = '0;
          por_d = 1'b0;
          idx_d = '0;
          // A held button keeps the domains parked here until it is let go.
          if (!rst_sync || btn_evt) begin
            step_d = '0;
          end else if (step_q == STEP_LAST) begin
            step_d  = '0;
            state_d = WAIT_LOCK;
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        WAIT_LOCK: begin
          step_d = '0;
          if (lock_sync) state_d = RELEASE;
        end
        RELEASE: begin
          if (step_q == STEP_LAST) begin
            step_d = '0;
            idx_d  = idx_q + 1'b1;
            for (int i = 0; i < NUM_OUTS; i++) begin
              if (idx_q == IW'(i)) rst_d[i] = 1'b1;
            end
            if (idx_q == IDX_LAST) begin
              state_d = RUN;
              por_d   = 1'b1;
            end
          end else begin
            step_d = step_q + 1'b1;
          end
        end
        RUN: begin
          rst_d = '1;
          por_d = 1'b1;
        end
        default: state_d = HOLD;
      endcase
    end
  end

  assign rst_n_out   = rst_q;
  assign por_done    = por_q;
  assign reset_cause = cause_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer with NUM_OUTS=3, SYNC_STAGES=2,
// STAGE_DELAY=4, DEBOUNCE_CYCLES=8; outputs are sampled 1 ns after each rising edge.
`timescale 1ns/1ps
module tb_reset_sequencer;

  logic       clkout;
  logic       ext_reset;
  logic       pll_lock;
  logic       btn_rst_n;
  logic       sw_req;
  logic [2:0] rst_n_out;
  logic       por_done;
  logic [1:0] reset_cause;
  logic [1:0] state_o;

  int total  = 0;
  int passed = 0;

  typedef struct {
    string      name;
    int         adv;
    logic       rst;
    logic       lock;
    logic       btn;
    logic       sw;
    logic [2:0] er;
    logic       ep;
    logic [1:0] ec;
    logic [1:0] es;
  } vec_t;

  vec_t vecs[$];

  reset_sequencer #(
    .NUM_OUTS        (3),
    .SYNC_STAGES     (2),
    .STAGE_DELAY     (4),
    .DEBOUNCE_CYCLES (8)
  ) dut (
    .clkout      (clkout),
    .ext_reset   (ext_reset),
    .pll_lock    (pll_lock),
    .btn_rst_n   (btn_rst_n),
    .sw_req      (sw_req),
    .rst_n_out   (rst_n_out),
    .por_done    (por_done),
    .reset_cause (reset_cause),
    .state_o     (state_o)
  );

  initial begin
    clkout = 1'b0;
    forever #5 clkout = ~clkout;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clkout);
    #1;
  endtask

  task automatic check(input string name, input logic [2:0] er, input logic ep,
                       input logic [1:0] ec, input logic [1:0] es);
    total++;
    if (rst_n_out !== er || por_done !== ep || reset_cause !== ec || state_o !== es) begin
      $display("FAIL %s: got rst_n_out=%b por_done=%b reset_cause=%0d state_o=%0d, want rst_n_out=%b por_done=%b reset_cause=%0d state_o=%0d",
               name, rst_n_out, por_done, reset_cause, state_o, er, ep, ec, es);
    end else begin
      passed++;
    end
  endtask

  function automatic void add(input string n, input int a, input logic r, input logic l,
                              input logic b, input logic s, input logic [2:0] er,
                              input logic ep, input logic [1:0] ec, input logic [1:0] es);
    vec_t v;
    v.name = n; v.adv = a; v.rst = r; v.lock = l; v.btn = b; v.sw = s;
    v.er = er; v.ep = ep; v.ec = ec; v.es = es;
    vecs.push_back(v);
  endfunction

  initial begin
    ext_reset = 1'b0;
    pll_lock  = 1'b1;
    btn_rst_n = 1'b1;
    sw_req    = 1'b0;

    // Power-on with lock already high; ext_reset rises at cycle 0.
    add("reset_state", 3, 0, 1, 1, 0, 3'b000, 0, 2'd0, 2'd0);
    add("po_hold_c5",  5, 1, 1, 1, 0, 3'b000, 0, 2'd0, 2'd0);
    add("po_wait_c6",  1, 1, 1, 1, 0, 3'b000, 0, 2'd0, 2'd1);
    add("po_rel_c7",   1, 1, 1, 1, 0, 3'b000, 0, 2'd0, 2'd2);
    add("po_c10",      3, 1, 1, 1, 0, 3'b000, 0, 2'd0, 2'd2);
    add("po_c11",      1, 1, 1, 1, 0, 3'b001, 0, 2'd0, 2'd2);
    add("po_c14",      3, 1, 1, 1, 0, 3'b001, 0, 2'd0, 2'd2);
    add("po_c15",      1, 1, 1, 1, 0, 3'b011, 0, 2'd0, 2'd2);
    add("po_c18",      3, 1, 1, 1, 0, 3'b011, 0, 2'd0, 2'd2);
    add("po_c19",      1, 1, 1, 1, 0, 3'b111, 1, 2'd0, 2'd3);
    add("run_steady",  5, 1, 1, 1, 0, 3'b111, 1, 2'd0, 2'd3);
    // Software request in RUN, then re-sequence.
    add("sw_run",      1, 1, 1, 1, 1, 3'b000, 0, 2'd2, 2'd0);
    add("sw_hold",     3, 1, 1, 1, 0, 3'b000, 0, 2'd2, 2'd0);
    add("sw_wait",     1, 1, 1, 1, 0, 3'b000, 0, 2'd2, 2'd1);
    add("sw_rel",      1, 1, 1, 1, 0, 3'b000, 0, 2'd2, 2'd2);
    add("sw_bit0",     4, 1, 1, 1, 0, 3'b001, 0, 2'd2, 2'd2);
    add("sw_run_again",8, 1, 1, 1, 0, 3'b111, 1, 2'd2, 2'd3);
    // ext_reset clears the cause; then late lock at cycle 30, sw_req ignored in WAIT_LOCK.
    add("rst_clears",  2, 0, 0, 1, 0, 3'b000, 0, 2'd0, 2'd0);
    add("ll_wait_c6",  6, 1, 0, 1, 0, 3'b000, 0, 2'd0, 2'd1);
    add("ll_wait_c20",14, 1, 0, 1, 0, 3'b000, 0, 2'd0, 2'd1);
    add("ll_sw_ignored",1, 1, 0, 1, 1, 3'b000, 0, 2'd0, 2'd1);
    add("ll_wait_c30", 9, 1, 0, 1, 0, 3'b000, 0, 2'd0, 2'd1);
    add("ll_wait_c32", 2, 1, 1, 1, 0, 3'b000, 0, 2'd0, 2'd1);
    add("ll_rel_c33",  1, 1, 1, 1, 0, 3'b000, 0, 2'd0, 2'd2);
    add("ll_c36",      3, 1, 1, 1, 0, 3'b000, 0, 2'd0, 2'd2);
    add("ll_c37",      1, 1, 1, 1, 0, 3'b001, 0, 2'd0, 2'd2);
    add("ll_run_c45",  8, 1, 1, 1, 0, 3'b111, 1, 2'd0, 2'd3);

    foreach (vecs[i]) begin
      ext_reset = vecs[i].rst;
      pll_lock  = vecs[i].lock;
      btn_rst_n = vecs[i].btn;
      sw_req    = vecs[i].sw;
      tick(vecs[i].adv);
      check(vecs[i].name, vecs[i].er, vecs[i].ep, vecs[i].ec, vecs[i].es);
    end
    sw_req = 1'b0;

    // Short 5-cycle button glitch must not trigger.
    btn_rst_n = 1'b0;
    tick(5);
    btn_rst_n = 1'b1;
    check("btn_short_mid", 3'b111, 1, 2'd0, 2'd3);
    tick(12);
    check("btn_short_after", 3'b111, 1, 2'd0, 2'd3);

    // 20-cycle hold: assert at press+11, stay in HOLD until after release.
    btn_rst_n = 1'b0;
    tick(10);
    check("btn_p10", 3'b111, 1, 2'd0, 2'd3);
    tick(1);
    check("btn_p11", 3'b000, 0, 2'd1, 2'd0);
    tick(9);
    check("btn_p20_held", 3'b000, 0, 2'd1, 2'd0);
    btn_rst_n = 1'b1;
    tick(6);
    check("btn_p26_hold", 3'b000, 0, 2'd1, 2'd0);
    tick(1);
    check("btn_p27_wait", 3'b000, 0, 2'd1, 2'd1);
    tick(1);
    check("btn_p28_rel", 3'b000, 0, 2'd1, 2'd2);
    tick(4);
    check("btn_p32_bit0", 3'b001, 0, 2'd1, 2'd2);
    tick(8);
    check("btn_p40_run", 3'b111, 1, 2'd1, 2'd3);

    // Lock loss in RUN.
    pll_lock = 1'b0;
    tick(2);
    check("lock_run_d2", 3'b111, 1, 2'd1, 2'd3);
    tick(1);
    check("lock_run_d3", 3'b000, 0, 2'd3, 2'd0);
    pll_lock = 1'b1;
    tick(9);
    check("lock_reseq_bit0", 3'b001, 0, 2'd3, 2'd2);

    // Software request in RELEASE sets cause 2.
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    check("sw_in_release", 3'b000, 0, 2'd2, 2'd0);
    tick(9);
    check("sw_reseq_bit0", 3'b001, 0, 2'd2, 2'd2);

    // Lock loss in RELEASE coinciding with sw_req: lock loss wins.
    pll_lock = 1'b0;
    tick(2);
    check("lock_sw_d2", 3'b001, 0, 2'd2, 2'd2);
    sw_req = 1'b1;
    tick(1);
    sw_req = 1'b0;
    check("lock_sw_d3", 3'b000, 0, 2'd3, 2'd0);
    pll_lock = 1'b1;
    tick(13);
    check("abort_pre", 3'b011, 0, 2'd3, 2'd2);

    // 1 ns ext_reset pulse mid-RELEASE, then the full power-on timing again.
    ext_reset = 1'b0;
    #0.5;
    check("abort_async", 3'b000, 0, 2'd0, 2'd0);
    #0.5;
    ext_reset = 1'b1;
    tick(10);
    check("abort_c10", 3'b000, 0, 2'd0, 2'd2);
    tick(1);
    check("abort_c11", 3'b001, 0, 2'd0, 2'd2);
    tick(4);
    check("abort_c15", 3'b011, 0, 2'd0, 2'd2);
    tick(4);
    check("abort_c19", 3'b111, 1, 2'd0, 2'd3);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
